// File: rtl/dec_to_bin_accumulator.sv
// Decimal-to-binary entry accumulator.
// Takes decimal digits one at a time and builds acc = acc*10 + digit.
// On commit it publishes the N-bit result. The result saturates at
// 2^N-1 and sets a sticky overflow flag. A digit above 9 sets a sticky
// bad_digit flag and is otherwise ignored.
//
// Handshakes:
// - A digit transfers on a rising edge where digit_valid && digit_ready.
//   digit_ready depends on state only (IDLE/ACCUM), never on digit_valid.
// - commit is a level, sampled in IDLE/ACCUM/FULL and ignored elsewhere.
// - Priority within one cycle is clear > commit > digit.
// - value_valid pulses for the single DONE cycle.
module dec_to_bin_accumulator #(
    parameter int N          = 6,
    parameter int MAX_DIGITS = 2,
    localparam int CW        = $clog2(MAX_DIGITS + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [3:0]   digit,
    input  logic         digit_valid,
    output logic         digit_ready,
    input  logic         commit,
    output logic [N-1:0] value,
    output logic         value_valid,
    output logic [CW-1:0] count,
    output logic         overflow,
    output logic         bad_digit,
    output logic [2:0]   state_dbg
);

    localparam int AW   = N + 4;
    localparam int MAXV = (1 << N) - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        MUL   = 3'd2,
        FULL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] acc;
    logic [AW-1:0] prod;
    logic [3:0]    digit_q;
    logic          fresh;          // a commit finished; the next entry clears the flags
    logic          take_commit;
    logic          take_digit;
    logic          take_bad;
    logic          last_digit;

    assign digit_ready = (state == IDLE) || (state == ACCUM);
    assign value_valid = (state == DONE);
    assign state_dbg   = state;
    assign prod        = (acc << 3) + (acc << 1) + AW'(digit_q);
    assign last_digit  = (count == CW'(MAX_DIGITS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and accept decode, applying clear > commit > digit
    always_comb begin
        state_nxt   = state;
        take_commit = 1'b0;
        take_digit  = 1'b0;
        take_bad    = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (commit) begin
                        take_commit = 1'b1;
                        state_nxt   = DONE;
                    end else if (digit_valid) begin
                        if (digit <= 4'd9) begin
                            take_digit = 1'b1;
                            state_nxt  = MUL;
                        end else begin
                            take_bad = 1'b1;
                        end
                    end
                end
                MUL:  state_nxt = last_digit ? FULL : ACCUM;
                FULL: begin
                    if (commit) begin
                        take_commit = 1'b1;
                        state_nxt   = DONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: accumulator, digit count, published value and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            count     <= '0;
            digit_q   <= '0;
            value     <= '0;
            overflow  <= 1'b0;
            bad_digit <= 1'b0;
            fresh     <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            bad_digit <= 1'b0;
            fresh     <= 1'b0;
        end else begin
            if (take_commit) begin
                value <= acc[N-1:0];
                fresh <= 1'b1;
            end
            if (take_digit) begin
                digit_q <= digit;
                if (fresh) begin
                    overflow  <= 1'b0;
                    bad_digit <= 1'b0;
                    fresh     <= 1'b0;
                end
            end
            if (take_bad) begin
                // A bad digit after a finished entry still starts the new entry's flags
                bad_digit <= 1'b1;
                if (fresh) begin
                    overflow <= 1'b0;
                    fresh    <= 1'b0;
                end
            end
            if (state == MUL) begin
                count <= count + CW'(1);
                if (prod > AW'(MAXV)) begin
                    acc      <= AW'(MAXV);
                    overflow <= 1'b1;
                end else begin
                    acc <= prod;
                end
            end
            if (state == DONE) begin
                acc   <= '0;
                count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dec_to_bin_accumulator.sv
// Directed bench for dec_to_bin_accumulator (N=6, MAX_DIGITS=2).
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_dec_to_bin_accumulator;

    localparam int N  = 6;
    localparam int CW = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACCUM = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_FULL  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [3:0]    digit = 4'd0;
    logic          digit_valid = 1'b0;
    logic          digit_ready;
    logic          commit = 1'b0;
    logic [N-1:0]  value;
    logic          value_valid;
    logic [CW-1:0] count;
    logic          overflow;
    logic          bad_digit;
    logic [2:0]    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    dec_to_bin_accumulator #(.N(N), .MAX_DIGITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .digit(digit),
        .digit_valid(digit_valid), .digit_ready(digit_ready), .commit(commit),
        .value(value), .value_valid(value_valid), .count(count),
        .overflow(overflow), .bad_digit(bad_digit), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one valid digit for a single cycle, then let the MUL cycle run
    task automatic send_digit(input logic [3:0] d);
        digit = d; digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
        step();
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (value !== 6'd0) begin n_fail++; $display("FAIL reset_value got %0d want 0", value); end
        n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if ({value_valid, overflow, bad_digit} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {value_valid, overflow, bad_digit}); end
        rst_n = 1'b1;
        step();
        n_checks++; if (digit_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", digit_ready); end
        n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", state_dbg, S_IDLE); end
    endtask

    task automatic test_basic_entry();
        digit = 4'd4; digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
        n_checks++; if (state_dbg !== S_MUL || digit_ready !== 1'b0) begin n_fail++; $display("FAIL basic_mul state %0d ready %b want %0d 0", state_dbg, digit_ready, S_MUL); end
        step();
        n_checks++; if (count !== 2'd1 || state_dbg !== S_ACCUM) begin n_fail++; $display("FAIL basic_count1 got %0d st %0d want 1 %0d", count, state_dbg, S_ACCUM); end
        send_digit(4'd2);
        n_checks++; if (count !== 2'd2 || state_dbg !== S_FULL || digit_ready !== 1'b0) begin n_fail++; $display("FAIL basic_full cnt %0d st %0d rdy %b want 2 %0d 0", count, state_dbg, digit_ready, S_FULL); end
        do_commit();
        n_checks++; if (value !== 6'd42 || value_valid !== 1'b1) begin n_fail++; $display("FAIL basic_value got %0d vv %b want 42 1", value, value_valid); end
        n_checks++; if (overflow !== 1'b0 || bad_digit !== 1'b0) begin n_fail++; $display("FAIL basic_flags got %b%b want 00", overflow, bad_digit); end
        step();
        n_checks++; if (value_valid !== 1'b0 || value !== 6'd42 || count !== 2'd0) begin n_fail++; $display("FAIL basic_after vv %b val %0d cnt %0d want 0 42 0", value_valid, value, count); end
    endtask

    task automatic test_overflow();
        send_digit(4'd7);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", overflow); end
        send_digit(4'd5);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
        do_commit();
        n_checks++; if (value !== 6'd63 || value_valid !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_value got %0d vv %b ovf %b want 63 1 1", value, value_valid, overflow); end
        step();
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        digit = 4'd3; digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_newclear got %b want 0", overflow); end
        step();
        do_clear();
    endtask

    task automatic test_bad_digit();
        digit = 4'd12; digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
        n_checks++; if (bad_digit !== 1'b1 || count !== 2'd0 || state_dbg !== S_IDLE) begin n_fail++; $display("FAIL bad_set bd %b cnt %0d st %0d want 1 0 %0d", bad_digit, count, state_dbg, S_IDLE); end
        send_digit(4'd9);
        n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL bad_count got %0d want 1", count); end
        do_commit();
        n_checks++; if (value !== 6'd9 || value_valid !== 1'b1 || bad_digit !== 1'b1) begin n_fail++; $display("FAIL bad_value got %0d vv %b bd %b want 9 1 1", value, value_valid, bad_digit); end
        step();
        do_clear();
        n_checks++; if (bad_digit !== 1'b0) begin n_fail++; $display("FAIL bad_clear got %b want 0", bad_digit); end
    endtask

    task automatic test_full_hold();
        send_digit(4'd1);
        send_digit(4'd2);
        digit = 4'd3; digit_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (digit_ready !== 1'b0 || count !== 2'd2) begin n_fail++; $display("FAIL full_hold%0d rdy %b cnt %0d want 0 2", i, digit_ready, count); end
        end
        do_commit();
        digit_valid = 1'b0;
        n_checks++; if (value !== 6'd12 || value_valid !== 1'b1) begin n_fail++; $display("FAIL full_value got %0d vv %b want 12 1", value, value_valid); end
        step();
    endtask

    task automatic test_commit_cases();
        do_commit();
        n_checks++; if (value !== 6'd0 || value_valid !== 1'b1) begin n_fail++; $display("FAIL idle_commit got %0d vv %b want 0 1", value, value_valid); end
        step();
        digit = 4'd5; digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
        commit = 1'b1;
        step();
        commit = 1'b0;
        n_checks++; if (value_valid !== 1'b0 || state_dbg !== S_ACCUM || count !== 2'd1) begin n_fail++; $display("FAIL mul_commit vv %b st %0d cnt %0d want 0 %0d 1", value_valid, state_dbg, count, S_ACCUM); end
        clear = 1'b1; commit = 1'b1;
        step();
        clear = 1'b0; commit = 1'b0;
        n_checks++; if (value_valid !== 1'b0 || count !== 2'd0 || value !== 6'd0) begin n_fail++; $display("FAIL clear_commit vv %b cnt %0d val %0d want 0 0 0", value_valid, count, value); end
        send_digit(4'd8);
        digit = 4'd4; digit_valid = 1'b1; commit = 1'b1;
        step();
        digit_valid = 1'b0; commit = 1'b0;
        n_checks++; if (value !== 6'd8 || value_valid !== 1'b1) begin n_fail++; $display("FAIL commit_over_digit got %0d vv %b want 8 1", value, value_valid); end
        step();
        n_checks++; if (state_dbg !== S_IDLE || count !== 2'd0) begin n_fail++; $display("FAIL commit_over_digit_idle st %0d cnt %0d want %0d 0", state_dbg, count, S_IDLE); end
    endtask

    task automatic test_reset_mid_mul();
        send_digit(4'd4);
        digit = 4'd6; digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (state_dbg !== S_IDLE || count !== 2'd0 || value !== 6'd0) begin n_fail++; $display("FAIL rst_mul st %0d cnt %0d val %0d want 0 0 0", state_dbg, count, value); end
        n_checks++; if ({value_valid, overflow, bad_digit} !== 3'b000) begin n_fail++; $display("FAIL rst_mul_flags got %b want 000", {value_valid, overflow, bad_digit}); end
        #3;
        rst_n = 1'b1;
        step();
        n_checks++; if (digit_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mul_ready got %b want 1", digit_ready); end
        send_digit(4'd3);
        do_commit();
        n_checks++; if (value !== 6'd3 || value_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mul_value got %0d vv %b want 3 1", value, value_valid); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_overflow();
        test_bad_digit();
        test_full_hold();
        test_commit_cases();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_to_bin_accumulator.md
Name: dec_to_bin_accumulator

Overview:
Sequential decimal-to-binary converter and the inverse of the tens/units binary-to-decimal display path. Decimal digits arrive one at a time from a keypad or switch strobe. Each accepted digit updates an accumulator as acc = acc*10 + digit. On commit the block presents the N-bit binary value to the datapath, e.g. as a subtractor operand, with overflow and invalid-digit flags.

Parameters:
N, 6, width of binary result; maximum representable value is 2^N-1.
MAX_DIGITS, 2, maximum decimal digits per entry.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort: discard entry and clear flags
digit  input  4  BCD digit, valid range 0..9
digit_valid  input  1  digit strobe
digit_ready  output  1  block can accept a digit this cycle
commit  input  1  finish entry and publish result
value  output  N  last committed binary value, held until next commit
value_valid  output  1  one-cycle pulse, value updated
count  output  $clog2(MAX_DIGITS+1)  digits accepted in current entry
overflow  output  1  sticky, entry exceeded 2^N-1
bad_digit  output  1  sticky, digit >9 was presented

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, acc=0, count=0, value=0, value_valid=0, overflow=0, bad_digit=0. digit_ready=1 once reset is released.
- Internal accumulator width is N+4 bits, enough to hold (2^N-1)*10+9 before saturation.
- States:
  - IDLE: count=0.
  - ACCUM: 0<count<MAX_DIGITS.
  - MUL: one-cycle update.
  - FULL: count=MAX_DIGITS.
  - DONE: one cycle.
- digit_ready=1 only in IDLE and ACCUM; it is 0 in MUL, FULL and DONE. digit_ready is decoded from state only and never depends on digit_valid.
- Digit accept happens at an edge where digit_valid && digit_ready:
  - digit 0..9: latch the digit and go to MUL.
  - digit >9: set bad_digit. The digit is dropped and state, acc and count are unchanged.
- MUL, one cycle:
  - acc <= (acc<<3)+(acc<<1)+digit, count <= count+1.
  - If the result exceeds 2^N-1, set overflow and acc <= 2^N-1 (saturate).
  - Next state is FULL if count+1==MAX_DIGITS, else ACCUM.
- Digit latency: accept edge, then acc updated at the following edge. The next digit can be accepted 2 cycles after the previous one.
- Commit:
  - Accepted in IDLE, ACCUM and FULL; ignored (not queued) in MUL and DONE.
  - On the accept edge: value <= acc[N-1:0] (already saturated), go to DONE.
  - value_valid=1 for exactly the DONE cycle. The next state is IDLE with acc=0 and count=0.
  - Commit in IDLE publishes value=0.
- Flags:
  - overflow and bad_digit remain valid during the value_valid pulse.
  - Both are cleared by clear, or by the first accepted digit of a new entry after DONE.
  - They are not cleared by commit.
- Priority within one cycle: clear > commit > digit.
  - clear in any state: go to IDLE with acc=0, count=0, flags=0, value_valid=0. value keeps the last committed value.
  - clear and commit together: clear wins and no value_valid is produced.
  - commit and digit_valid together in IDLE/ACCUM: commit wins and the digit is not consumed.
- Reset mid-MUL or mid-DONE: immediate return to reset values; any partial entry is lost.
- Arithmetic is unsigned only; there is no sign digit.

Test Plan:
1. Reset, digit 4, digit 2, commit (N=6) -> count 1 then 2, FULL after second digit with digit_ready=0; value=42, value_valid one-cycle pulse, overflow=0, bad_digit=0.
2. Digit 7, digit 5, commit -> overflow=1 after second MUL; value=63, pulse with overflow=1. A new digit 3 then clears overflow.
3. Digit 12 in IDLE, then digit 9, commit -> bad_digit=1, count stays 0 after 12; value=9, bad_digit still 1 at pulse.
4. Digit 1, digit 2, then digit_valid held with digit 3 -> digit_ready=0 in FULL, count stays 2; commit gives value=12.
5. Commit in IDLE -> value=0 with pulse. Commit asserted during MUL -> ignored, no pulse. clear and commit in the same cycle after digit 5 -> no pulse, count=0, value unchanged.
6. Digit 6 accepted, rst_n low during MUL -> all outputs at reset values asynchronously. After release, digit 3 then commit -> value=3.
